// File: rtl/dp_bram_arbiter.sv
// Round-robin arbiter in front of a true dual-port BRAM: two grants per cycle,
// a read tag pipeline and per-client response registers.
module dp_bram_rsp_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int CW         = 2,
  parameter int ID         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  va,
  input  logic [CW-1:0]         ca,
  input  logic [DATA_WIDTH-1:0] da,
  input  logic                  vb,
  input  logic [CW-1:0]         cb,
  input  logic [DATA_WIDTH-1:0] db,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);
  logic hit_a, hit_b;

  assign hit_a = va && (ca == CW'(ID));
  assign hit_b = vb && (cb == CW'(ID));

  // A client never owns both ports in one cycle, so at most one hit is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= hit_a || hit_b;
      if (hit_a)      rsp_rdata <= da;
      else if (hit_b) rsp_rdata <= db;
    end
  end
endmodule

module dp_bram_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_CLIENTS = 4,
  parameter int OUT_REG     = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            req_valid,
  input  logic [NUM_CLIENTS-1:0]            req_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]            req_ready,
  output logic [NUM_CLIENTS-1:0]            rsp_valid,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0] rsp_rdata,
  output logic [15:0]                       conflict_cnt
);
  localparam int CW    = $clog2(NUM_CLIENTS);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [CW-1:0] rr_ptr, a_idx, b_idx, last_idx, nxt_ptr;
  logic          a_found, b_found, conflict, a_go, b_go;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  // Port A: first valid from rr_ptr; port B: next valid after A's winner.
  always_comb begin
    int c;
    c        = 0;
    a_found  = 1'b0;
    a_idx    = '0;
    b_found  = 1'b0;
    b_idx    = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_CLIENTS) c = c - NUM_CLIENTS;
      if (!a_found && req_valid[CW'(c)]) begin
        a_found = 1'b1;
        a_idx   = CW'(c);
      end
    end
    for (int k = 1; k < NUM_CLIENTS; k++) begin
      c = int'(a_idx) + k;
      if (c >= NUM_CLIENTS) c = c - NUM_CLIENTS;
      if (a_found && !b_found && req_valid[CW'(c)]) begin
        b_found = 1'b1;
        b_idx   = CW'(c);
      end
    end
    conflict = a_found && b_found && (addr_v[a_idx] == addr_v[b_idx]) &&
               (req_we[a_idx] || req_we[b_idx]);
  end

  assign a_go     = a_found && rst_n;
  assign b_go     = b_found && !conflict && rst_n;
  assign last_idx = b_go ? b_idx : a_idx;
  assign nxt_ptr  = (last_idx == CW'(NUM_CLIENTS-1)) ? '0 : last_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (a_go) req_ready[a_idx] = 1'b1;
    if (b_go) req_ready[b_idx] = 1'b1;
  end

  // Memory is never reset; reads return the word held before this edge's writes.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] da0, db0;

  always_ff @(posedge clk) begin
    if (a_go && req_we[a_idx]) mem[addr_v[a_idx]] <= wdata_v[a_idx];
    if (b_go && req_we[b_idx]) mem[addr_v[b_idx]] <= wdata_v[b_idx];
    da0 <= mem[addr_v[a_idx]];
    db0 <= mem[addr_v[b_idx]];
  end

  logic          va0, vb0;
  logic [CW-1:0] ca0, cb0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      va0          <= 1'b0;
      vb0          <= 1'b0;
      ca0          <= '0;
      cb0          <= '0;
      conflict_cnt <= '0;
    end else begin
      if (a_go) rr_ptr <= nxt_ptr;
      va0 <= a_go && !req_we[a_idx];
      vb0 <= b_go && !req_we[b_idx];
      ca0 <= a_idx;
      cb0 <= b_idx;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  logic                  fa_v, fb_v;
  logic [CW-1:0]         fa_c, fb_c;
  logic [DATA_WIDTH-1:0] fa_d, fb_d;

  if (OUT_REG != 0) begin : g_oreg
    logic                  va1, vb1;
    logic [CW-1:0]         ca1, cb1;
    logic [DATA_WIDTH-1:0] da1, db1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        va1 <= 1'b0;
        vb1 <= 1'b0;
        ca1 <= '0;
        cb1 <= '0;
      end else begin
        va1 <= va0;
        vb1 <= vb0;
        ca1 <= ca0;
        cb1 <= cb0;
      end
    end
    always_ff @(posedge clk) begin
      da1 <= da0;
      db1 <= db0;
    end
    assign fa_v = va1;
    assign fb_v = vb1;
    assign fa_c = ca1;
    assign fb_c = cb1;
    assign fa_d = da1;
    assign fb_d = db1;
  end else begin : g_noreg
    assign fa_v = va0;
    assign fb_v = vb0;
    assign fa_c = ca0;
    assign fb_c = cb0;
    assign fa_d = da0;
    assign fb_d = db0;
  end

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_lane
    dp_bram_rsp_lane #(.DATA_WIDTH(DATA_WIDTH), .CW(CW), .ID(i)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .va        (fa_v),
      .ca        (fa_c),
      .da        (fa_d),
      .vb        (fb_v),
      .cb        (fb_c),
      .db        (fb_d),
      .rsp_valid (rsp_valid[i]),
      .rsp_rdata (rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_dp_bram_arbiter.sv
// Directed bench for dp_bram_arbiter: grants checked per cycle, read data
// checked by a response monitor against a per-client expectation queue.
module tb_dp_bram_arbiter;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NC = 4;
  localparam int OR = 0;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NC-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [NC*AW-1:0]   req_addr;
  logic [NC*DW-1:0]   req_wdata, rsp_rdata;
  logic [15:0]        conflict_cnt;

  dp_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CLIENTS(NC), .OUT_REG(OR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t          sb [NC][$];
  logic [DW-1:0] mdl [int];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NC*AW-1:0] pa(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [NC*DW-1:0] pd(input logic [DW-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  // One request cycle: drive, check grants, record expectations, cross the edge.
  task automatic step(input logic [NC-1:0] v, input logic [NC-1:0] we,
                      input logic [NC*AW-1:0] a, input logic [NC*DW-1:0] d,
                      input logic [NC-1:0] exp_rdy, input bit track);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NC; i++) begin
      if (v[i] && req_ready[i] && !we[i] && track) begin
        exp_t e;
        e.d   = mdl[int'(a[i*AW +: AW])];
        e.due = cyc + 2 + OR;
        sb[i].push_back(e);
      end
    end
    for (int i = 0; i < NC; i++)
      if (v[i] && req_ready[i] && we[i]) mdl[int'(a[i*AW +: AW])] = d[i*DW +: DW];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, '0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t me;
    for (int i = 0; i < NC; i++) begin
      if (rsp_valid[i]) begin
        if (sb[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: client %0d got data %0h expected no response (cycle %0d)",
                   i, rsp_rdata[i*DW +: DW], cyc);
        end else begin
          me = sb[i].pop_front();
          chk("rsp_data", 32'(rsp_rdata[i*DW +: DW]), 32'(me.d));
          chk("rsp_cycle", 32'(cyc), 32'(me.due));
        end
      end
    end
  end

  initial begin
    int left;
    req_valid = '1;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'h0);
    chk("rst_rdata", 32'(rsp_rdata[DW-1:0]), 32'h0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single client write then read-back.
    step(4'b0001, 4'b0001, pa(10'h010, 0, 0, 0), pd(16'hBEEF, 0, 0, 0), 4'b0001, 1'b1);
    step(4'b0001, 4'b0000, pa(10'h010, 0, 0, 0), '0, 4'b0001, 1'b1);

    for (int j = 0; j < 8; j++)
      step(4'b0001, 4'b0001, pa(AW'(10'h100 + j), 0, 0, 0), pd(DW'(16'hA000 + j), 0, 0, 0),
           4'b0001, 1'b0);
    step(4'b0001, 4'b0001, pa(10'h005, 0, 0, 0), pd(16'h5555, 0, 0, 0), 4'b0001, 1'b0);
    idle(3);

    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All four clients reading from reset: pairs (0,1),(2,3),(0,1).
    step(4'hF, 4'h0, pa(10'h100, 10'h101, 10'h102, 10'h103), '0, 4'b0011, 1'b1);
    step(4'hF, 4'h0, pa(10'h104, 10'h105, 10'h102, 10'h103), '0, 4'b1100, 1'b1);
    step(4'hF, 4'h0, pa(10'h104, 10'h105, 10'h106, 10'h107), '0, 4'b0011, 1'b1);

    // Lone client 3 brings rr_ptr back to 0.
    step(4'b1000, 4'h0, pa(0, 0, 0, 10'h103), '0, 4'b1000, 1'b1);

    // Same-address write pair: only port A issues, client 1 follows.
    step(4'b0011, 4'b0011, pa(10'h020, 10'h020, 0, 0), pd(16'h1111, 16'h2222, 0, 0), 4'b0001, 1'b1);
    chk("conflict_cnt_1", 32'(conflict_cnt), 32'h1);
    step(4'b0010, 4'b0010, pa(0, 10'h020, 0, 0), pd(0, 16'h2222, 0, 0), 4'b0010, 1'b1);
    step(4'b0001, 4'b0000, pa(10'h020, 0, 0, 0), '0, 4'b0001, 1'b1);

    // Same-address read pair is not a conflict.
    step(4'b1100, 4'b0000, pa(0, 0, 10'h005, 10'h005), '0, 4'b1100, 1'b1);
    chk("conflict_cnt_rr", 32'(conflict_cnt), 32'h1);
    idle(3);

    // Reset with two reads in flight: they must never respond.
    step(4'b0011, 4'b0000, pa(10'h100, 10'h101, 0, 0), '0, 4'b0011, 1'b0);
    rst_n     = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("rst3_ready", 32'(req_ready), 32'h0);
    chk("rst3_rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    chk("conflict_cnt_rst", 32'(conflict_cnt), 32'h0);
    step(4'b0011, 4'b0000, pa(10'h010, 10'h104, 0, 0), '0, 4'b0011, 1'b1);
    idle(3);

    // Sustained conflicts saturate the counter.
    req_valid = 4'b0011;
    req_we    = 4'b0011;
    req_addr  = pa(10'h030, 10'h030, 0, 0);
    req_wdata = pd(16'h0001, 16'h0002, 0, 0);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("conflict_cnt_fffe", 32'(conflict_cnt), 32'hFFFE);
    @(posedge clk);
    @(negedge clk);
    chk("conflict_cnt_ffff", 32'(conflict_cnt), 32'hFFFF);
    repeat (5000) @(posedge clk);
    @(negedge clk);
    chk("conflict_cnt_sat", 32'(conflict_cnt), 32'hFFFF);
    @(posedge clk);
    #1;
    idle(3);

    left = 0;
    for (int i = 0; i < NC; i++) left += sb[i].size();
    chk("responses_outstanding", 32'(left), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
